pipe_skid_stage: RTL

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_stage
// Purpose  : Two-entry valid/ready pipeline stage (main + skid register).
//            in_ready is decoded from registered state only, so there is no
//            combinational path from out_ready to in_ready. It supports a
//            flush that drops held beats and a saturating stall counter.
// Ports    : clk          - single clock; all state changes on posedge
//            rst_n        - synchronous active-low reset
//            in_valid     - upstream beat present
//            in_ready     - stage can accept a beat this cycle
//            in_data      - upstream payload [DATA_W]
//            flush        - discard all held beats
//            out_valid    - downstream beat present
//            out_ready    - downstream accepts
//            out_data     - downstream payload [DATA_W] (main register)
//            occupancy    - beats held (0..2)
//            stall_count  - saturating count of back-pressured cycles [CNT_W]
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
    parameter int DATA_W        = 71,
    parameter int CNT_W         = 16,
    parameter int ZERO_ON_FLUSH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_count
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  C_STALL_MAX = '1;
    localparam logic [CNT_W-1:0]  C_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] C_ZERO_DATA = '0;
    localparam bit                C_CLR_ON_FL = (ZERO_ON_FLUSH != 0);

    state_t            r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [CNT_W-1:0]  r_stall;

    logic w_accept;
    logic w_pop;

    assign in_ready    = (r_state != FULL);
    assign out_valid   = (r_state != EMPTY);
    assign out_data    = r_main;
    assign occupancy   = r_state;
    assign stall_count = r_stall;

    assign w_accept = in_valid & in_ready;
    assign w_pop    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_main  <= C_ZERO_DATA;
            r_skid  <= C_ZERO_DATA;
            r_stall <= '0;
        end else begin
            // Stall counting looks only at the output handshake, so a flush
            // neither clears nor skips it.
            if (out_valid && !out_ready && (r_stall != C_STALL_MAX)) begin
                r_stall <= r_stall + C_CNT_ONE;
            end

            if (flush) begin
                // Flush wins over any simultaneous accept or pop.
                r_state <= EMPTY;
                if (C_CLR_ON_FL) begin
                    r_main <= C_ZERO_DATA;
                    r_skid <= C_ZERO_DATA;
                end
            end else begin
                case (r_state)
                    EMPTY: begin
                        if (w_accept) begin
                            r_state <= ONE;
                            r_main  <= in_data;
                        end
                    end
                    ONE: begin
                        if (w_accept && !w_pop) begin
                            r_state <= FULL;
                            r_skid  <= in_data;
                        end else if (w_pop && !w_accept) begin
                            r_state <= EMPTY;
                        end else if (w_accept && w_pop) begin
                            // Pass-through: new beat replaces the departing one.
                            r_main  <= in_data;
                        end
                    end
                    FULL: begin
                        // in_ready is low here, so only a pop can occur.
                        if (w_pop) begin
                            r_state <= ONE;
                            r_main  <= r_skid;
                        end
                    end
                    default: begin
                        r_state <= EMPTY;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
